// File: rtl/demux16_1x4_buf.sv
// Registered 1-to-4 demultiplexer: steers a WIDTH-bit word into one of four single-entry lanes.
// Latency: a word accepted at a clock edge is visible on its lane immediately after that edge (1 cycle).
// Backpressure: i_ready drops while the addressed lane is full (DEMUX_ACK_BYPASS_EN lets a same-cycle ack free it).
module demux16_1x4_buf #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i,
    input  logic [1:0]       select,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [3:0]       O_valid,
    input  logic [3:0]       O_ack,
    output logic [CNT_W-1:0] count
);

    logic [3:0][WIDTH-1:0] lane_dat;
    logic [3:0]            lane_vld;
    logic [CNT_W-1:0]      xfer_cnt;
    logic                  accept;
    logic [3:0]            wr_en;

    // Readiness depends only on the addressed lane, so a full lane never stalls writes to other lanes.
`ifdef DEMUX_ACK_BYPASS_EN
    assign i_ready = ~lane_vld[select] | O_ack[select];
`else
    assign i_ready = ~lane_vld[select];
`endif

    assign accept = i_valid & i_ready;

    // One-hot write enable for the lane addressed by an accepted word.
    always_comb begin
        wr_en = 4'b0000;
        if (accept) begin
            wr_en[select] = 1'b1;
        end
    end

    // Lane state: a write sets valid and loads data (winning over a same-cycle ack); an ack only clears valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_dat <= '0;
            lane_vld <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (wr_en[n]) begin
                    lane_dat[n] <= i;
                    lane_vld[n] <= 1'b1;
                end else if (O_ack[n]) begin
                    lane_vld[n] <= 1'b0;
                end
            end
        end
    end

    // Wrapping count of accepted transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    assign O0      = lane_dat[0];
    assign O1      = lane_dat[1];
    assign O2      = lane_dat[2];
    assign O3      = lane_dat[3];
    assign O_valid = lane_vld;
    assign count   = xfer_cnt;

endmodule

// File: tb/tb_demux16_1x4_buf.sv
// Self-checking bench for demux16_1x4_buf: directed table, hand-written corner sequences, random traffic.
// Reference model holds lane contents/occupancy in plain arrays and applies the handshake rules per cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit after each rising edge.
module tb_demux16_1x4_buf;

`ifdef DEMUX_ACK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] i;
    logic [1:0]  select;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] O0, O1, O2, O3;
    logic [3:0]  O_valid;
    logic [3:0]  O_ack;
    logic [7:0]  count;

    demux16_1x4_buf dut (
        .clk     (clk),
        .reset   (reset),
        .i       (i),
        .select  (select),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .O0      (O0),
        .O1      (O1),
        .O2      (O2),
        .O3      (O3),
        .O_valid (O_valid),
        .O_ack   (O_ack),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [15:0] m_o [4];
    bit          m_ov [4];
    int          m_cnt;
    logic        last_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_o[n]  = 16'h0;
            m_ov[n] = 1'b0;
        end
        m_cnt = 0;
    endtask

    function automatic logic [3:0] m_ov_vec();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = m_ov[n];
        return v;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".O_valid"}, 32'(O_valid), 32'(m_ov_vec()));
        chk({tag, ".count"},   32'(count),   32'(m_cnt));
        chk({tag, ".O0"},      32'(O0),      32'(m_o[0]));
        chk({tag, ".O1"},      32'(O1),      32'(m_o[1]));
        chk({tag, ".O2"},      32'(O2),      32'(m_o[2]));
        chk({tag, ".O3"},      32'(O3),      32'(m_o[3]));
    endtask

    // One clock cycle: drive, check ready, advance model, clock, check state. Entered and left just after negedge.
    task automatic cycle(input logic [15:0] d, input logic [1:0] s, input logic v, input logic [3:0] a);
        bit m_rdy;
        i = d; select = s; i_valid = v; O_ack = a;
        #1;
        m_rdy = !m_ov[s] || (BYP && a[s]);
        last_rdy = i_ready;
        chk("i_ready", 32'(i_ready), 32'(m_rdy));
        for (int n = 0; n < 4; n++) if (a[n]) m_ov[n] = 1'b0;
        if (v && m_rdy) begin
            m_o[s]  = d;
            m_ov[s] = 1'b1;
            m_cnt   = (m_cnt + 1) % 256;
        end
        @(posedge clk);
        #1;
        check_state("cyc");
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
        logic        v;
        logic [3:0]  a;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [7:0]  e_cnt;
        logic [15:0] e_o0, e_o1, e_o2, e_o3;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Directed vectors starting from reset state
        tbl[0]  = '{16'h000F, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'd1, 16'h000F, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{16'h00FF, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 8'd2, 16'h000F, 16'h00FF, 16'h0000, 16'h0000};
        tbl[2]  = '{16'h0FFF, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 8'd3, 16'h000F, 16'h00FF, 16'h0FFF, 16'h0000};
        tbl[3]  = '{16'hFFFF, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 8'd4, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        tbl[4]  = '{16'h1234, 2'd2, 1'b1, 4'b0000, 1'b0, 4'b1111, 8'd4, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        tbl[5]  = '{16'h0000, 2'd1, 1'b0, 4'b0101, 1'b0, 4'b1010, 8'd4, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        tbl[6]  = '{16'h0000, 2'd1, 1'b0, 4'b0101, 1'b0, 4'b1010, 8'd4, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        tbl[7]  = '{16'hA5A5, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b1011, 8'd5, 16'hA5A5, 16'h00FF, 16'h0FFF, 16'hFFFF};
        tbl[8]  = '{16'h5A5A, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b1111, 8'd6, 16'hA5A5, 16'h00FF, 16'h5A5A, 16'hFFFF};
        tbl[9]  = '{16'h0000, 2'd1, 1'b0, 4'b1000, 1'b0, 4'b0111, 8'd6, 16'hA5A5, 16'h00FF, 16'h5A5A, 16'hFFFF};
        tbl[10] = '{16'hA5A5, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 8'd7, 16'hA5A5, 16'h00FF, 16'h5A5A, 16'hA5A5};

        reset = 1'b1; i = '0; select = '0; i_valid = 1'b0; O_ack = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_state("por");

        // Reach O_valid=1010, count=5, then reset asynchronously mid-cycle
        cycle(16'h1111, 2'd0, 1'b1, 4'b0000);
        cycle(16'h0000, 2'd0, 1'b0, 4'b0001);
        cycle(16'h2222, 2'd1, 1'b1, 4'b0000);
        cycle(16'h3333, 2'd2, 1'b1, 4'b0000);
        cycle(16'h4444, 2'd3, 1'b1, 4'b0000);
        cycle(16'h5555, 2'd0, 1'b1, 4'b0101);
        cycle(16'h0000, 2'd0, 1'b0, 4'b0001);
        chk("pre_rst.O_valid", 32'(O_valid), 32'h0000000A);
        chk("pre_rst.count", 32'(count), 32'd5);
        i_valid = 1'b0; O_ack = 4'b0000;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst.O_valid", 32'(O_valid), 32'h0);
        chk("rst.count", 32'(count), 32'h0);
        chk("rst.O0", 32'(O0), 32'h0);
        chk("rst.O1", 32'(O1), 32'h0);
        chk("rst.O2", 32'(O2), 32'h0);
        chk("rst.O3", 32'(O3), 32'h0);
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            #1 chk("rst.i_ready", 32'(i_ready), 32'h1);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cycle(16'hDEAD, 2'(s), 1'b0, 4'b0000);
            chk("post_rst.i_ready", 32'(last_rdy), 32'h1);
        end

        // Table-driven directed vectors
        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].d, tbl[k].s, tbl[k].v, tbl[k].a);
            chk($sformatf("tbl%0d.i_ready", k), 32'(last_rdy), 32'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d.O_valid", k), 32'(O_valid), 32'(tbl[k].e_ov));
            chk($sformatf("tbl%0d.count", k), 32'(count), 32'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d.O0", k), 32'(O0), 32'(tbl[k].e_o0));
            chk($sformatf("tbl%0d.O1", k), 32'(O1), 32'(tbl[k].e_o1));
            chk($sformatf("tbl%0d.O2", k), 32'(O2), 32'(tbl[k].e_o2));
            chk($sformatf("tbl%0d.O3", k), 32'(O3), 32'(tbl[k].e_o3));
        end

        // Same-lane ack + write
        cycle(16'h0000, 2'd0, 1'b0, 4'b1111);
        cycle(16'h1111, 2'd0, 1'b1, 4'b0000);
        cycle(16'h2222, 2'd0, 1'b1, 4'b0001);
        if (BYP) begin
            chk("byp.i_ready", 32'(last_rdy), 32'h1);
            chk("byp.O0", 32'(O0), 32'h2222);
            chk("byp.O_valid0", 32'(O_valid[0]), 32'h1);
        end else begin
            chk("nobyp.i_ready", 32'(last_rdy), 32'h0);
            chk("nobyp.O0", 32'(O0), 32'h1111);
            chk("nobyp.O_valid0", 32'(O_valid[0]), 32'h0);
            cycle(16'h2222, 2'd0, 1'b1, 4'b0000);
            chk("nobyp2.i_ready", 32'(last_rdy), 32'h1);
            chk("nobyp2.O0", 32'(O0), 32'h2222);
            chk("nobyp2.O_valid0", 32'(O_valid[0]), 32'h1);
        end

        // Counter wrap: 256 accepted writes from count=0; each lane is acked the cycle before its next write
        reset = 1'b1;
        #1 model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 256; k++) begin
            cycle(16'(k * 257), 2'(k % 4), 1'b1, 4'(1 << ((k + 1) % 4)));
            if (k == 254) chk("wrap.count254", 32'(count), 32'd255);
        end
        chk("wrap.count", 32'(count), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cycle(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux16_1x4_buf.md
Name: demux16_1x4_buf

Overview:
- Registered 1-to-4 demultiplexer for 16-bit words. It is the write-side counterpart of the datapath's 16-bit 4:1 select mux.
- An incoming word is steered by a 2-bit select into one of four single-entry output lanes.
- Each lane holds its word until the lane's consumer acknowledges it.
- Used to distribute ALU/bus results to four destinations (register banks, output ports) under a valid/ready handshake.

Parameters:
- WIDTH, 16, data width of input and of each lane.
- CNT_W, 8, width of the wrapping accepted-transfer counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- i  input  WIDTH  input data word.
- select  input  2  destination lane for i (0..3).
- i_valid  input  1  producer has a word on i/select.
- i_ready  output  1  combinational; lane addressed by select can accept this cycle.
- O0, O1, O2, O3  output  WIDTH each  lane data registers.
- O_valid  output  4  bit n = lane n holds an unacknowledged word.
- O_ack  input  4  bit n = consumer of lane n takes the word this cycle.
- count  output  CNT_W  number of accepted transfers, modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, immediate on reset=1):
  - O0..O3 = 0, O_valid = 4'b0000, count = 0.
  - Any in-flight handshake is discarded.
  - i_ready follows the combinational rule below from the reset state, so it is 1 during reset whenever the bypass rule allows it.
- Accept condition: accept = i_valid & i_ready.
- On the clock edge with accept:
  - O[select] <= i.
  - O_valid[select] <= 1.
  - count <= count + 1, wrapping from 2^CNT_W-1 to 0.
- Latency: a word accepted at edge k is visible on O[select] with O_valid[select]=1 immediately after edge k (1 cycle).
- Lanes not addressed by an accept keep their data unchanged.
- O_ack[n] with O_valid[n]=1 at an edge: O_valid[n] <= 0. Data in O[n] is retained (not cleared).
- O_ack[n] with O_valid[n]=0: ignored, no state change.
- Multiple lanes may be acked in the same cycle. Acks on lanes other than select are independent of the accept.
- i_ready (without bypass) = ~O_valid[select].
- i_valid=0: no state change besides acks. i_ready is still driven from select.
- A full lane blocks only producers addressing it. A write to an empty lane proceeds while other lanes are full.
- Same-lane accept and ack in one cycle is only possible under the optional feature. In that case the new word wins: O_valid stays 1 and O holds the new data.
- Lane data registers hold their value whenever O_valid[n]=1 and there is no accept to lane n. There is no overwrite of unacknowledged data, ever.

Optional Feature:
- Macro DEMUX_ACK_BYPASS_EN.
- Defined: i_ready = ~O_valid[select] | O_ack[select]. A full lane being acked this cycle accepts a new word in the same cycle, giving one word per cycle per lane sustained throughput.
- Not defined: i_ready = ~O_valid[select]. After an ack, a lane needs one empty cycle before it accepts again, giving at most one word every 2 cycles per lane.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check: assert reset mid-run with O_valid=4'b1010, count=5 -> immediately O_valid=0, O0..O3=0, count=0. After release, i_ready=1 for every select.
- Fill all four lanes:
  - Stimulus: i=16'h000F,16'h00FF,16'h0FFF,16'hFFFF with select=0,1,2,3, one per cycle, i_valid=1, O_ack=0.
  - Response: O0..O3 hold those values, O_valid=4'b1111, count=4.
  - Then select=2, i_valid=1 -> i_ready=0, O2 stays 16'h0FFF.
- Independent lanes: lane 1 full and not acked, write 16'hA5A5 to select=3 -> accepted next edge, O3=16'hA5A5, O1 unchanged, count+1.
- Ack behaviour:
  - Stimulus: O_ack=4'b0101 with O_valid=4'b1111.
  - Response: next O_valid=4'b1010, O0/O2 data retained.
  - O_ack on an empty lane -> no change.
- Same-lane ack+write (lane 0 full with 16'h1111; i=16'h2222, select=0, i_valid=1, O_ack[0]=1):
  - With DEMUX_ACK_BYPASS_EN: i_ready=1, next O0=16'h2222, O_valid[0]=1.
  - Without it: i_ready=0, O_valid[0]=0 next cycle, word accepted one cycle later.
- Counter wrap: 256 accepted writes from count=0 (CNT_W=8) -> count returns to 0. Counter never increments on cycles with i_valid=1 & i_ready=0.
